// File: rtl/rf_scb.sv
// Register file with NRD combinational read ports, one write port and a
// per-register pending scoreboard. Define RF_BYPASS_EN for same-cycle write-through.
module rf_scb #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [AW-1:0]     dbg_sel,
  output logic [DW-1:0]     dbg_data,
  output logic [AW:0]       pend_cnt
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     pend_cnt_nxt;
  logic            wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  // Issue is applied after the write clear so a same-cycle claim on the
  // register being written leaves it pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_hit)
      pend_nxt[wr_addr] = 1'b0;
    if (flush)
      pend_nxt = '0;
    else if (iss_en && (iss_addr != '0))
      pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    pend_cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++)
      pend_cnt_nxt = pend_cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++)
        rf[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_hit)
        rf[wr_addr] <= wr_data;
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (ra != '0) begin
        rd_data[k*DW +: DW] = rf[ra];
        rd_busy[k]          = pend[ra];
      end
`ifdef RF_BYPASS_EN
      if (rst_n && wr_hit && (wr_addr == ra)) begin
        rd_data[k*DW +: DW] = wr_data;
        rd_busy[k]          = 1'b0;
      end
`endif
    end
  end

  assign dbg_data = (dbg_sel != '0) ? rf[dbg_sel] : '0;

endmodule

// File: tb/tb_rf_scb.sv
// Directed bench for rf_scb: scoreboard counting, flush, bypass and async reset.
module tb_rf_scb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW-1:0]     dbg_sel;
  logic [DW-1:0]     dbg_data;
  logic [AW:0]       pend_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  rf_scb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; dbg_sel = '0;
    #12;
    check("reset_rd_data",  rd_data,  64'h0);
    check("reset_rd_busy",  rd_busy,  2'b00);
    check("reset_pend_cnt", pend_cnt, 6'd0);
    check("reset_dbg",      dbg_data, 32'h0);
    rst_n = 1'b1;

    // Write r5, read it back on the next cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
    step(); idle();
    dbg_sel = 5'd5;
    rd(5'd5, 5'd0);
    check("wr5_rd0",  rd_data[31:0], 32'h1234_5678);
    check("wr5_dbg",  dbg_data,      32'h1234_5678);

    // r0 is never written nor pending.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    step(); idle();
    rd(5'd0, 5'd0);
    check("r0_data", rd_data, 64'h0);
    check("r0_busy", rd_busy, 2'b00);
    check("r0_cnt",  pend_cnt, 6'd0);

    // Issue r3 then r7, then write r3.
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    check("iss3_cnt", pend_cnt, 6'd1);
    iss_addr = 5'd7;
    step(); idle();
    check("iss7_cnt", pend_cnt, 6'd2);
    rd(5'd3, 5'd7);
    check("iss_busy", rd_busy, 2'b11);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    step(); idle();
    rd(5'd3, 5'd7);
    check("wr3_cnt",  pend_cnt,      6'd1);
    check("wr3_busy", rd_busy,       2'b10);
    check("wr3_data", rd_data[31:0], 32'hA5);

    // Same-cycle write and issue of r9: claim wins, data still written.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    iss_en = 1'b1; iss_addr = 5'd9;
    step(); idle();
    rd(5'd9, 5'd0);
    check("wi9_cnt",  pend_cnt,      6'd2);
    check("wi9_busy", rd_busy[0],    1'b1);
    check("wi9_data", rd_data[31:0], 32'h55);

    // Flush overrides a simultaneous issue.
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    check("iss4_cnt", pend_cnt, 6'd3);
    flush = 1'b1; iss_addr = 5'd6;
    step(); idle();
    rd(5'd4, 5'd6);
    check("flush_cnt",  pend_cnt, 6'd0);
    check("flush_busy", rd_busy,  2'b00);

    // Write to a pending register read on both ports in the same cycle.
    iss_en = 1'b1; iss_addr = 5'd2;
    step(); idle();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hDEAD;
    rd(5'd2, 5'd2);
`ifdef RF_BYPASS_EN
    check("byp_data", rd_data, {32'hDEAD, 32'hDEAD});
    check("byp_busy", rd_busy, 2'b00);
`else
    check("nobyp_data", rd_data, 64'h0);
    check("nobyp_busy", rd_busy, 2'b11);
`endif
    step(); idle();
    rd(5'd2, 5'd2);
    check("wr2_data", rd_data, {32'hDEAD, 32'hDEAD});
    check("wr2_busy", rd_busy, 2'b00);
    check("wr2_cnt",  pend_cnt, 6'd0);

    // Asynchronous reset mid-sequence clears everything, bypass included.
    iss_en = 1'b1; iss_addr = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
    step();
    iss_en = 1'b0;
    wr_addr = 5'd10; wr_data = 32'h99;
    dbg_sel = 5'd10;
    rd(5'd10, 5'd8);
    check("pre_rst_cnt", pend_cnt, 6'd1);
    check("pre_rst_dbg", dbg_data, 32'h77);
    rst_n = 1'b0;
    #1;
    check("rst_data", rd_data,  64'h0);
    check("rst_busy", rd_busy,  2'b00);
    check("rst_dbg",  dbg_data, 32'h0);
    check("rst_cnt",  pend_cnt, 6'd0);
    step();
    check("rst_hold_dbg", dbg_data, 32'h0);
    rst_n = 1'b1;
    wr_data = 32'h33;
    step(); idle();
    check("post_rst_dbg", dbg_data, 32'h33);
    rd(5'd10, 5'd8);
    check("post_rst_rd", rd_data, {32'h0, 32'h33});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
